// File: rtl/sram_arb_pkg.sv
// Shared constants and state encoding for the 1024x36 single-port SRAM arbiter.
package sram_arb_pkg;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 36;
  localparam int MEM_DEPTH = 1024;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;
endpackage

// File: rtl/sram_resp_fifo.sv
// Per-requester read-response FIFO; head entry is presented combinationally, 0 when empty.
module sram_resp_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_vld,
  input  logic              pop_rdy,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_vld  = (count != '0);
  assign pop      = pop_vld && pop_rdy;
  assign pop_data = pop_vld ? store[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_vld) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push_vld) store[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sram_1rw_arbiter_1024x36.sv
// Zero-fills a 1024x36 1RW SRAM after reset, then round-robin shares its port
// among NUM_REQ requesters with credit-based, per-requester read-response FIFOs.
module sram_1rw_arbiter_1024x36
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int RESP_DEPTH  = 3,
  parameter int INIT_ENABLE = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      init_done,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [NUM_REQ*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_en,
  output logic                      mem_wmode,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  state_e             state;
  state_e             state_nxt;
  logic [ADDR_W-1:0]  init_cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] elig;
  logic [CRD_W-1:0]   credit;
  logic [PTR_W-1:0]   cand;
  logic               gnt_vld_p0;
  logic [PTR_W-1:0]   gnt_id_p0;
  logic               rd_vld_p1;
  logic [PTR_W-1:0]   rd_id_p1;
  logic [CNT_W-1:0]   fifo_cnt [NUM_REQ];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if (INIT_ENABLE != 0) state <= ST_INIT;
      else                  state <= ST_RUN;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == ADDR_W'(MEM_DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Credits count FIFO entries plus the read in flight, so a granted read always has room.
  always_comb begin
    elig   = '0;
    credit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      credit  = CRD_W'(fifo_cnt[i]) + CRD_W'(rd_vld_p1 && (rd_id_p1 == PTR_W'(i)));
      elig[i] = req_valid[i] && (req_write[i] || (credit < CRD_W'(RESP_DEPTH)));
    end
  end

  // ---- stage p0: round-robin grant, macro port driven combinationally
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_id_p0  = '0;
    cand       = '0;
    if (state == ST_RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!gnt_vld_p0 && elig[cand]) begin
          gnt_vld_p0 = 1'b1;
          gnt_id_p0  = cand;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      rd_id_p1  <= '0;
    end else begin
      if (gnt_vld_p0)
        rr_ptr <= (gnt_id_p0 == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id_p0 + PTR_W'(1);
      rd_vld_p1 <= gnt_vld_p0 && !req_write[gnt_id_p0];
      rd_id_p1  <= gnt_id_p0;
    end
  end

  // Outputs are forced quiet while reset is held, even though INIT is the reset state.
  assign init_done = (state == ST_RUN) && !reset;

  always_comb begin
    req_ready = '0;
    if (gnt_vld_p0 && !reset) req_ready[gnt_id_p0] = 1'b1;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = init_cnt;
      end else if (gnt_vld_p0) begin
        mem_en    = 1'b1;
        mem_wmode = req_write[gnt_id_p0];
        mem_addr  = req_addr[gnt_id_p0*ADDR_W +: ADDR_W];
        if (req_write[gnt_id_p0]) mem_wdata = req_wdata[gnt_id_p0*DATA_W +: DATA_W];
      end
    end
  end

  // ---- stage p1: macro read data lands in the owning requester's FIFO
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
    sram_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_vld  (rd_vld_p1 && (rd_id_p1 == PTR_W'(g))),
      .push_data (mem_rdata),
      .pop_vld   (resp_valid[g]),
      .pop_rdy   (resp_ready[g]),
      .pop_data  (resp_rdata[g*DATA_W +: DATA_W]),
      .count     (fifo_cnt[g])
    );
  end
endmodule

// File: tb/tb_sram_1rw_arbiter_1024x36.sv
// Bench for sram_1rw_arbiter_1024x36: behavioural macro, reference memory and response scoreboard.
module tb_sram_1rw_arbiter_1024x36;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic [19:0] req_addr;
  logic [71:0] req_wdata, resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_en, mem_wmode;
  logic [35:0] mem_wdata, mem_rdata;

  logic [35:0]   macro [1024];
  logic [1023:0] wr_seen = '0;
  logic [35:0]   ref_mem [1024];
  logic [35:0]   q0[$];
  logic [35:0]   q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops0 = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Macro model: never-written words return a non-zero pattern so the zero-fill is observable.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        macro[mem_addr]   <= mem_wdata;
        wr_seen[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wr_seen[mem_addr] ? macro[mem_addr] : {26'h3AB_CDEF, mem_addr};
      end
    end
  end

  sram_1rw_arbiter_1024x36 #(.NUM_REQ(2), .RESP_DEPTH(3), .INIT_ENABLE(1)) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [35:0] pat(input int k);
    return 36'h5_A5A5_0000 ^ (36'(k) * 36'h0_0001_0101);
  endfunction

  // Called at every negedge: tracks accepted requests and compares popped responses.
  task automatic sb();
    logic [9:0]  a;
    logic [35:0] got, exp;
    int          qs;
    if (reset) begin
      foreach (ref_mem[k]) ref_mem[k] = '0;
      q0.delete();
      q1.delete();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        a = req_addr[i*10 +: 10];
        if (req_write[i]) ref_mem[a] = req_wdata[i*36 +: 36];
        else if (i == 0) q0.push_back(ref_mem[a]);
        else q1.push_back(ref_mem[a]);
      end
      if (resp_valid[i] && resp_ready[i]) begin
        got = resp_rdata[i*36 +: 36];
        qs = (i == 0) ? q0.size() : q1.size();
        checks++;
        if (qs == 0) begin
          errors++;
          $display("FAIL sb_unexpected_resp%0d: got %h, required no response", i, got);
        end else begin
          exp = (i == 0) ? q0.pop_front() : q1.pop_front();
          if (i == 0) pops0++;
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_rdata%0d: got %h, required %h", i, got, exp);
          end
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [9:0] a,
                         input logic [35:0] d, input logic v);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*10 +: 10]  = a;
    req_wdata[i*36 +: 36] = d;
  endtask

  task automatic step();
    @(negedge clock);
    sb();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input int i, input logic w, input logic [9:0] a,
                        input logic [35:0] d, output int acc);
    set_req(i, w, a, d, 1'b1);
    acc = -1;
    for (int n = 0; n < 20 && acc < 0; n++) begin
      @(negedge clock);
      sb();
      if (req_ready[i]) acc = cyc;
      @(posedge clock);
      #1;
    end
    req_valid[i] = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL req_timeout%0d: got no req_ready, required acceptance within 20 cycles", i);
    end
  endtask

  task automatic drain(input int n);
    resp_ready = 2'b11;
    repeat (n) step();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: got %0d/%0d outstanding, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_write = 2'b11;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b, required 0", init_done); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b, required 00", req_ready); end
    checks++;
    if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid: got %b, required 00", resp_valid); end
    checks++;
    if ({mem_en, mem_wmode, mem_addr, mem_wdata} !== 48'h0) begin
      errors++;
      $display("FAIL rst_mem_port: got en=%b wm=%b a=%h d=%h, required all 0", mem_en, mem_wmode, mem_addr, mem_wdata);
    end
  endtask

  // Releases reset and follows the full zero-fill sweep with writers held valid.
  task automatic test_init();
    set_req(0, 1'b1, 10'd1, 36'hF_FFFF_FFFF, 1'b1);
    set_req(1, 1'b1, 10'd2, 36'hF_FFFF_FFFF, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clock);
      sb();
      checks++;
      if ({mem_en, mem_wmode, mem_addr, mem_wdata, req_ready, init_done} !== {2'b11, 10'(k), 36'h0, 3'b000}) begin
        errors++;
        $display("FAIL init_cycle%0d: got en=%b wm=%b a=%h d=%h rdy=%b done=%b, required 1 1 %h 0 00 0",
                 k, mem_en, mem_wmode, mem_addr, mem_wdata, req_ready, init_done, 10'(k));
      end
      @(posedge clock);
      #1;
    end
    req_valid = 2'b00;
    @(negedge clock);
    sb();
    checks++;
    if (init_done !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL init_done_run: got done=%b en=%b, required 1 0", init_done, mem_en);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_init_read();
    int acc;
    bit seen;
    resp_ready = 2'b11;
    seen = 0;
    do_req(0, 1'b0, 10'h3FF, 36'h0, acc);
    for (int n = 0; n < 5 && !seen; n++) begin
      @(negedge clock);
      if (resp_valid[0]) begin
        seen = 1;
        checks++;
        if (resp_rdata[35:0] !== 36'h0) begin
          errors++;
          $display("FAIL init_read_3ff: got %h, required 0", resp_rdata[35:0]);
        end
      end
      sb();
      @(posedge clock);
      #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL init_read_timeout: got no resp_valid, required a response"); end
  endtask

  task automatic test_raw();
    resp_ready = 2'b01;
    set_req(0, 1'b1, 10'd5, 36'h1_2345_6789, 1'b1);
    @(negedge clock);
    checks++;
    if ({req_ready[0], mem_en, mem_wmode, mem_addr, mem_wdata} !== {3'b111, 10'd5, 36'h1_2345_6789}) begin
      errors++;
      $display("FAIL raw_write_grant: got rdy=%b en=%b wm=%b a=%h d=%h, required 1 1 1 005 123456789",
               req_ready[0], mem_en, mem_wmode, mem_addr, mem_wdata);
    end
    sb();
    @(posedge clock);
    #1;
    req_write[0] = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready[0], mem_en, mem_wmode, mem_addr, mem_wdata} !== {3'b110, 10'd5, 36'h0}) begin
      errors++;
      $display("FAIL raw_read_grant: got rdy=%b en=%b wm=%b a=%h d=%h, required 1 1 0 005 0",
               req_ready[0], mem_en, mem_wmode, mem_addr, mem_wdata);
    end
    sb();
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clock);
    checks++;
    if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL raw_latency_early: got resp_valid=1 at T+1, required 0"); end
    sb();
    @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_rdata[35:0] !== 36'h1_2345_6789) begin
      errors++;
      $display("FAIL raw_resp_t2: got v=%b d=%h, required 1 123456789", resp_valid[0], resp_rdata[35:0]);
    end
    sb();
    @(posedge clock);
    #1;
  endtask

  task automatic test_alternate();
    int acc;
    logic [9:0] a0, a1;
    logic [1:0] exp_rdy;
    for (int k = 0; k < 4; k++) do_req(0, 1'b1, 10'(10 + k), 36'hA_0000_0000 | 36'(k), acc);
    for (int k = 0; k < 4; k++) do_req(1, 1'b1, 10'(20 + k), 36'hB_0000_0000 | 36'(k), acc);
    resp_ready = 2'b11;
    a0 = 10'd10;
    a1 = 10'd20;
    for (int n = 0; n < 8; n++) begin
      set_req(0, 1'b0, a0, 36'h0, 1'b1);
      set_req(1, 1'b0, a1, 36'h0, 1'b1);
      @(negedge clock);
      sb();
      exp_rdy = 2'b01 << (n % 2);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL alt_grant%0d: got %b, required %b", n, req_ready, exp_rdy);
      end
      if (req_ready[0]) a0 = a0 + 10'd1;
      if (req_ready[1]) a1 = a1 + 10'd1;
      @(posedge clock);
      #1;
    end
    req_valid = 2'b00;
    drain(6);
  endtask

  task automatic test_backpressure();
    int nacc;
    logic [9:0] a1;
    logic [1:0] exp_seq [4];
    resp_ready = 2'b00;
    nacc = 0;
    a1 = 10'd20;
    for (int n = 0; n < 6; n++) begin
      set_req(1, 1'b0, a1, 36'h0, 1'b1);
      @(negedge clock);
      sb();
      if (req_ready[1]) begin nacc++; a1 = a1 + 10'd1; end
      @(posedge clock);
      #1;
    end
    checks++;
    if (nacc != 3) begin errors++; $display("FAIL bp_accept_count: got %0d, required 3", nacc); end
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    for (int n = 0; n < 4; n++) begin
      set_req(0, 1'b1, 10'd50, pat(n), 1'b1);
      set_req(1, 1'b0, a1, 36'h0, 1'b1);
      resp_ready[1] = (n == 2);
      @(negedge clock);
      sb();
      checks++;
      if (req_ready !== exp_seq[n]) begin
        errors++;
        $display("FAIL bp_grant%0d: got %b, required %b", n, req_ready, exp_seq[n]);
      end
      if (req_ready[1]) a1 = a1 + 10'd1;
      @(posedge clock);
      #1;
    end
    req_valid = 2'b00;
    drain(8);
  endtask

  task automatic test_reset_midop();
    resp_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b0, 10'(10 + k), 36'h0, 1'b1);
      @(negedge clock);
      sb();
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL midop_accept%0d: got 0, required 1", k); end
      @(posedge clock);
      #1;
    end
    req_valid = 2'b00;
    checks++;
    if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL midop_fifo_nonempty: got 0, required 1"); end
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 2'b00 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_quiet: got resp_valid=%b mem_en=%b, required 00 0", resp_valid, mem_en);
    end
    repeat (2) step();
    test_init();
  endtask

  task automatic test_back_to_back();
    int miss_w, miss_r, p0;
    miss_w = 0;
    miss_r = 0;
    resp_ready = 2'b11;
    for (int k = 0; k < 100; k++) begin
      set_req(0, 1'b1, 10'(k), pat(k), 1'b1);
      @(negedge clock);
      sb();
      if (!req_ready[0]) miss_w++;
      @(posedge clock);
      #1;
    end
    p0 = pops0;
    for (int k = 0; k < 100; k++) begin
      set_req(0, 1'b0, 10'(k), 36'h0, 1'b1);
      @(negedge clock);
      sb();
      if (!req_ready[0]) miss_r++;
      @(posedge clock);
      #1;
    end
    req_valid = 2'b00;
    checks++;
    if (miss_w != 0) begin errors++; $display("FAIL b2b_write_stalls: got %0d, required 0", miss_w); end
    checks++;
    if (miss_r != 0) begin errors++; $display("FAIL b2b_read_stalls: got %0d, required 0", miss_r); end
    drain(6);
    checks++;
    if (pops0 - p0 != 100) begin errors++; $display("FAIL b2b_resp_count: got %0d, required 100", pops0 - p0); end
  endtask

  initial begin
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = '0;
    test_reset();
    test_init();
    test_init_read();
    test_raw();
    test_alternate();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no completion, required finish before 1 ms");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_1rw_arbiter_1024x36.md
Name: sram_1rw_arbiter_1024x36

Overview:
Controller that zero-initialises one 1024x36 single-port (1RW) SRAM macro after reset, then shares its RW port among NUM_REQ requesters. Each requester uses a valid/ready request channel and a valid/ready read-response channel. Grants are round-robin, and read responses are buffered per requester. The block sits between the client logic and the macro; the macro's clock input is tied to this block's clock.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
RESP_DEPTH, 3, entries per requester response FIFO (>=2)
INIT_ENABLE, 1, 1 = zero-fill all 1024 words after reset; 0 = enter RUN directly

Ports:
clock  in  1  single clock, also drives the macro
reset  in  1  asynchronous, active-high
init_done  out  1  high once RUN is entered
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted this cycle
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*10  word address, requester i at [10i+9:10i]
req_wdata  in  NUM_REQ*36  write data, requester i at [36i+35:36i]
resp_valid  out  NUM_REQ  read data available
resp_ready  in  NUM_REQ  read data consumed
resp_rdata  out  NUM_REQ*36  read data per requester
mem_addr  out  10  to macro address
mem_en  out  1  to macro enable
mem_wmode  out  1  to macro write mode
mem_wdata  out  36  to macro write data
mem_rdata  in  36  from macro; valid only in the cycle after a read enable

Behaviour:
- Reset (async assert) state: FSM = INIT (or RUN if INIT_ENABLE=0), init counter 0, RR pointer 0, FIFOs empty, in-flight flag clear.
- Outputs while reset is held: init_done 0, req_ready 0, resp_valid 0, mem_en 0, mem_wmode 0, mem_addr 0, mem_wdata 0.
- Reset asserted mid-operation: aborts any in-flight read and discards FIFO contents; INIT re-runs after reset is released.
- INIT state:
  - Each cycle drive mem_en=1, mem_wmode=1, mem_addr=counter, mem_wdata=0, then increment the counter.
  - After the write to address 1023, move to RUN. The full sequence is 1024 cycles.
  - req_ready stays 0 throughout INIT.
- RUN state:
  - init_done=1 (registered).
  - At most one grant per cycle.
- Eligibility: requester i is eligible if req_valid[i] is high and either:
  - it is a write, or
  - it is a read and credit[i] < RESP_DEPTH, where credit[i] = FIFO occupancy + in-flight read to i (registered values).
- A pop in the current cycle does not free a credit until the next cycle.
- Arbitration:
  - Round-robin starting from the pointer; the first eligible index wins.
  - req_ready[grant]=1, and it is combinationally dependent on req_valid.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Grant cycle T: mem_en=1, mem_wmode=req_write, mem_addr=req_addr. mem_wdata = req_wdata for writes, 0 for reads.
- No grant: mem_en=0, and addr/wdata/wmode are driven to 0.
- Write: committed at the end of cycle T. No response is generated.
- Read: an in-flight register records the target requester. In cycle T+1, mem_rdata is pushed into that requester's FIFO. resp_valid rises in T+2, giving 2-cycle latency with an empty FIFO.
- Read-after-write to the same address in consecutive grants returns the new data.
- Throughput: RESP_DEPTH=3 with resp_ready held 1 sustains one read per cycle for a single requester.
- FIFO behaviour:
  - Full and empty are never violated, because credits guarantee space.
  - Simultaneous push and pop is legal.
  - resp_rdata holds the head entry, or 0 when the FIFO is empty.

Decomposition:
- Package sram_arb_pkg: ADDR_W=10, DATA_W=36, MEM_DEPTH=1024, and the state enum {ST_INIT, ST_RUN}.
- Sub-module sram_resp_fifo: parameterised depth, 36-bit, valid/ready, synchronous push/pop, asynchronous reset. One instance per requester.

Test Plan:
- Reset release, INIT_ENABLE=1 -> mem_en=1/mem_wmode=1 with addresses 0..1023 over 1024 cycles, init_done=1 in cycle 1025; then a read of addr 0x3FF -> rdata 0.
- Req0 writes 0x123456789 to addr 5; next cycle req0 reads addr 5 -> resp_valid[0] exactly 2 cycles after acceptance, rdata 0x123456789.
- Req0 and req1 hold reads valid continuously with pointer 0 -> grants alternate 0,1,0,1; each requester receives its own data in order.
- Req1 reads with resp_ready[1]=0 -> exactly 3 accepted, then req_ready[1]=0 while req0 writes still granted; one pop -> next read accepted a cycle later.
- Reset asserted while a read is in flight with FIFO non-empty -> resp_valid=0 and mem_en=0 immediately; INIT restarts at address 0 after release.
- Single requester, resp_ready=1, 100 back-to-back reads to addresses 0..99 -> 100 grants in 100 consecutive cycles, data in order.
